// File: rtl/poly_horner_seq.sv
// Horner-rule polynomial sequencer: evaluates a0 + a1*t + ... + aN*t^N by issuing one
// multiply-accumulate per step to an external fixed-latency mac (y = c0 + c1*t).
module poly_horner_seq #(
   parameter int BC      = 16,
   parameter int BT      = 16,
   parameter int N_MAX   = 4,
   parameter int MAC_LAT = 3,
   localparam int BA     = $clog2(N_MAX + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cfg_we,
   input  logic [BA-1:0] cfg_addr,
   input  logic [BC-1:0] cfg_data,
   input  logic [BA-1:0] cfg_order,
   output logic          cfg_err,
   input  logic          s_valid,
   output logic          s_ready,
   input  logic [BT-1:0] s_t,
   output logic          m_valid,
   input  logic          m_ready,
   output logic [BC-1:0] m_y,
   output logic [BC-1:0] mac_c0,
   output logic [BC-1:0] mac_c1,
   output logic [BT-1:0] mac_t,
   input  logic [BC-1:0] mac_y,
   output logic          busy
);

   localparam int BW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
   localparam logic [BA-1:0] ADDR_MAX  = BA'(N_MAX);
   localparam logic [BA-1:0] ADDR_ONE  = BA'(1);
   localparam logic [BA-1:0] ADDR_ZERO = {BA{1'b0}};
   localparam logic [BW-1:0] WCNT_LAST = BW'(MAC_LAT - 1);
   localparam logic [BW-1:0] WCNT_ONE  = BW'(1);
   localparam logic [BW-1:0] WCNT_ZERO = {BW{1'b0}};

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_OUT} state_t;

   state_t        state_r, state_s;
   logic [BA-1:0] k_r, k_s;
   logic [BW-1:0] wcnt_r, wcnt_s;
   logic [BC-1:0] acc_r, acc_s;
   logic [BT-1:0] t_r, t_s;
   logic [BC-1:0] m_y_r, m_y_s;
   logic [BC-1:0] mac_c0_r, mac_c0_s, mac_c1_r, mac_c1_s;
   logic [BT-1:0] mac_t_r, mac_t_s;
   logic          m_valid_r, s_ready_r, busy_r, cfg_err_r;
   logic [BC-1:0] coef_r [0:N_MAX];
   // Private copy taken at accept so a same-cycle config write cannot leak into a running evaluation.
   logic [BC-1:0] snap_r [0:N_MAX];
   logic [BA-1:0] ord_s;
   logic          accept_s, cfg_ok_s;

   assign accept_s = s_valid && s_ready_r;
   assign ord_s    = (cfg_order > ADDR_MAX) ? ADDR_MAX : cfg_order;
   assign cfg_ok_s = cfg_we && (state_r == ST_IDLE) && (cfg_addr <= ADDR_MAX);

   // Next-state and next-value logic for the Horner sequencer.
   always_comb begin
      state_s  = state_r;
      k_s      = k_r;
      wcnt_s   = wcnt_r;
      acc_s    = acc_r;
      t_s      = t_r;
      m_y_s    = m_y_r;
      mac_c0_s = {BC{1'b0}};
      mac_c1_s = {BC{1'b0}};
      mac_t_s  = {BT{1'b0}};
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               t_s   = s_t;
               acc_s = coef_r[ord_s];
               if (ord_s == ADDR_ZERO) begin
                  m_y_s   = coef_r[0];
                  state_s = ST_OUT;
               end else begin
                  k_s      = ord_s - ADDR_ONE;
                  mac_c0_s = coef_r[ord_s - ADDR_ONE];
                  mac_c1_s = coef_r[ord_s];
                  mac_t_s  = s_t;
                  state_s  = ST_ISSUE;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            wcnt_s  = WCNT_ZERO;
            state_s = ST_WAIT;
         end
         ST_WAIT: begin
            if (wcnt_r == WCNT_LAST) begin
               acc_s = mac_y;
               if (k_r == ADDR_ZERO) begin
                  m_y_s   = mac_y;
                  state_s = ST_OUT;
               end else begin
                  k_s      = k_r - ADDR_ONE;
                  mac_c0_s = snap_r[k_r - ADDR_ONE];
                  mac_c1_s = mac_y;
                  mac_t_s  = t_r;
                  state_s  = ST_ISSUE;
               end
            end else begin
               wcnt_s = wcnt_r + WCNT_ONE;
            end
         end
         ST_OUT: begin
            if (m_ready) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_OUT;
            end
         end
         default: state_s = ST_IDLE;
      endcase
   end

   // Sequencer state and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= ST_IDLE;
         k_r       <= ADDR_ZERO;
         wcnt_r    <= WCNT_ZERO;
         acc_r     <= {BC{1'b0}};
         t_r       <= {BT{1'b0}};
         m_y_r     <= {BC{1'b0}};
         mac_c0_r  <= {BC{1'b0}};
         mac_c1_r  <= {BC{1'b0}};
         mac_t_r   <= {BT{1'b0}};
         m_valid_r <= 1'b0;
         s_ready_r <= 1'b0;
         busy_r    <= 1'b0;
      end else begin
         state_r   <= state_s;
         k_r       <= k_s;
         wcnt_r    <= wcnt_s;
         acc_r     <= acc_s;
         t_r       <= t_s;
         m_y_r     <= m_y_s;
         mac_c0_r  <= mac_c0_s;
         mac_c1_r  <= mac_c1_s;
         mac_t_r   <= mac_t_s;
         m_valid_r <= (state_s == ST_OUT);
         s_ready_r <= (state_s == ST_IDLE);
         busy_r    <= (state_s != ST_IDLE);
      end
   end

   // Coefficient register file, its evaluation snapshot and the dropped-write flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i <= N_MAX; i++) begin
            coef_r[i] <= {BC{1'b0}};
            snap_r[i] <= {BC{1'b0}};
         end
         cfg_err_r <= 1'b0;
      end else begin
         if (cfg_ok_s) begin
            coef_r[cfg_addr] <= cfg_data;
         end
         if (accept_s) begin
            for (int i = 0; i <= N_MAX; i++) begin
               snap_r[i] <= coef_r[i];
            end
         end
         cfg_err_r <= cfg_we && !cfg_ok_s;
      end
   end

   assign cfg_err = cfg_err_r;
   assign s_ready = s_ready_r;
   assign m_valid = m_valid_r;
   assign m_y     = m_y_r;
   assign mac_c0  = mac_c0_r;
   assign mac_c1  = mac_c1_r;
   assign mac_t   = mac_t_r;
   assign busy    = busy_r;

endmodule
